// File: rtl/mul_inv_seq_pkg.sv
// ============================================================================
// Module      : mul_inv_pkg (package)
// Description : Shared state encodings and constant helpers for mul_inv_seq.
//               Provides the FSM state constants, width helpers for the
//               remainder and step counter, and the saturation ceiling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_inv_pkg;

  // FSM state encodings
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to hold any value in [0, DEN]; the partial remainder is
  // always below DEN, so this many bits hold it between steps.
  function automatic int unsigned den_w(input int unsigned den);
    return $clog2(den + 1);
  endfunction

  // Bits needed for a down-counter that starts at prod_w.
  function automatic int unsigned cnt_w(input int unsigned prod_w);
    return $clog2(prod_w + 1);
  endfunction

  // All-ones ceiling for a data_w-bit level.
  function automatic logic [63:0] sat_max(input int unsigned data_w);
    return (64'd1 << data_w) - 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_inv_seq_restore_div_step.sv
// ============================================================================
// Module      : restore_div_step
// Description : One combinational restoring-division step. Appends the next
//               dividend bit to the partial remainder, subtracts the divisor
//               when it fits and reports the resulting quotient bit.
// Ports       : i_rem   - current partial remainder (REM_W bits)
//               i_bit   - next dividend bit, MSB first
//               o_rem   - updated partial remainder
//               o_qbit  - quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module restore_div_step #(
  parameter int unsigned REM_W = 5,
  parameter int unsigned DEN   = 9
) (
  input  logic [REM_W-1:0] i_rem,
  input  logic             i_bit,
  output logic [REM_W-1:0] o_rem,
  output logic             o_qbit
);

  localparam int unsigned        SH_W  = REM_W + 1;
  localparam logic [SH_W-1:0]    C_DEN = SH_W'(DEN);

  logic [SH_W-1:0] w_shift;
  logic [SH_W-1:0] w_res;
  logic            w_ge;

  // One spare bit above the remainder keeps the shifted value exact before
  // the compare; after a subtract the result is below DEN and fits REM_W.
  assign w_shift = {i_rem, i_bit};
  assign w_ge    = (w_shift >= C_DEN);
  assign w_res   = w_ge ? (w_shift - C_DEN) : w_shift;
  assign o_rem   = REM_W'(w_res);
  assign o_qbit  = w_ge;

endmodule

`default_nettype wire

// File: rtl/mul_inv_seq.sv
// ============================================================================
// Module      : mul_inv_seq
// Description : Sequential fixed-ratio gain, out = sat(round(in*NUM/DEN)).
//               The default 10/9 undoes a 0.9 brightness attenuation stage.
//               Uses a bit-serial restoring divider, one quotient bit per
//               clock, with a valid/ready handshake on each side.
// Ports       : clk       - system clock
//               rst_n     - synchronous active-low reset
//               in_valid  - input sample valid
//               in_ready  - block can accept a sample (IDLE)
//               in        - input level (DATA_W)
//               out_valid - result valid
//               out_ready - downstream accepts the result
//               out       - scaled, saturated level (DATA_W)
//               out_sat   - result saturated (only with MUL_INV_SAT_FLAG_EN)
// Options     : MUL_INV_SAT_FLAG_EN adds the out_sat flag port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_inv_seq
  import mul_inv_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM    = 10,
  parameter int unsigned DEN    = 9,
  parameter int unsigned PROD_W = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out
`ifdef MUL_INV_SAT_FLAG_EN
  ,
  output logic              out_sat
`endif
);

  localparam int unsigned        REM_W   = den_w(DEN) + 1;
  localparam int unsigned        CNT_W   = cnt_w(PROD_W);
  localparam logic [DATA_W-1:0]  SAT_MAX = DATA_W'(sat_max(DATA_W));

  if (DEN == 0) begin : g_den_zero
    $error("mul_inv_seq: DEN must be non-zero");
  end

  state_t            state_q, state_d;
  logic [PROD_W-1:0] dvd_q, dvd_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [PROD_W-1:0] quot_q, quot_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;

  logic [PROD_W-1:0] w_sum;
  logic [REM_W-1:0]  w_rem_nxt;
  logic              w_qbit;
  logic [PROD_W-1:0] w_quot_nxt;
  logic              w_sat;

  // Rounded dividend. With in and NUM both below 2^DATA_W and DEN/2 below
  // 2^(DATA_W-1), in*NUM + DEN/2 is strictly below 2^PROD_W, so PROD_W
  // bits hold it exactly and PROD_W division steps cover every bit.
  assign w_sum = (PROD_W'(in) * PROD_W'(NUM)) + PROD_W'(DEN / 2);

  restore_div_step #(
    .REM_W (REM_W),
    .DEN   (DEN)
  ) u_step (
    .i_rem  (rem_q),
    .i_bit  (dvd_q[PROD_W-1]),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  assign w_quot_nxt = (quot_q << 1) | PROD_W'(w_qbit);
  assign w_sat      = ((w_quot_nxt >> DATA_W) != '0);

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dvd_d   = w_sum;
          rem_d   = '0;
          quot_d  = '0;
          cnt_d   = CNT_W'(PROD_W);
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        dvd_d  = dvd_q << 1;
        rem_d  = w_rem_nxt;
        quot_d = w_quot_nxt;
        cnt_d  = cnt_q - CNT_W'(1);
        // The step taken while count is 1 is the last one; its quotient is
        // registered straight into out so out is valid on DONE entry.
        if (cnt_q == CNT_W'(1)) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_d       = w_sat ? SAT_MAX : w_quot_nxt[DATA_W-1:0];
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dvd_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef MUL_INV_SAT_FLAG_EN
  logic sat_q, sat_d;

  always_comb begin
    sat_d = sat_q;
    if (state_q == ST_IDLE && in_valid) begin
      sat_d = 1'b0;
    end else if (state_q == ST_CALC && cnt_q == CNT_W'(1)) begin
      sat_d = w_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign out_sat = sat_q;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_inv_seq.sv
// ============================================================================
// Module      : tb_mul_inv_seq
// Description : Self-checking bench for mul_inv_seq. Two instances run in
//               lockstep on shared stimulus: the default 10/9 gain and a
//               unity 1/1 gain. Vectors carry hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_inv_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready_a, out_valid_a;
  logic [7:0] out_a;
  logic       in_ready_b, out_valid_b;
  logic [7:0] out_b;
`ifdef MUL_INV_SAT_FLAG_EN
  logic       out_sat_a, out_sat_b;
`endif

  int checks   = 0;
  int failures = 0;

  mul_inv_seq u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in        (in_data),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out       (out_a)
`ifdef MUL_INV_SAT_FLAG_EN
    ,
    .out_sat   (out_sat_a)
`endif
  );

  mul_inv_seq #(
    .NUM (1),
    .DEN (1)
  ) u_dut_unity (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in        (in_data),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out       (out_b)
`ifdef MUL_INV_SAT_FLAG_EN
    ,
    .out_sat   (out_sat_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Accept one sample and wait for out_valid. lat counts the accept edge as
  // cycle 1 and the edge that raises out_valid as the last counted cycle.
  task automatic accept_wait(input logic [7:0] v, output int lat);
    @(negedge clk);
    chk("in_ready_at_accept", int'(in_ready_a), 1);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid_a && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("out_valid_seen", int'(out_valid_a), 1);
    chk("unity_lockstep_valid", int'(out_valid_b), 1);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_drop", int'(out_valid_a), 0);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
    logic       sat;
  } vec_t;

  vec_t vecs [10];
  int   lat;
  int   vals [3];
  int   exps [3];
  int   res  [3];
  int   tcy  [3];
  int   nres;
  int   idx;
  logic pre;
  int   model;

  initial begin
    vecs[0] = '{8'd0,   8'd0,   1'b0};
    vecs[1] = '{8'd9,   8'd10,  1'b0};
    vecs[2] = '{8'd90,  8'd100, 1'b0};
    vecs[3] = '{8'd229, 8'd254, 1'b0};
    vecs[4] = '{8'd255, 8'd255, 1'b1};
    vecs[5] = '{8'd230, 8'd255, 1'b1};
    vecs[6] = '{8'd1,   8'd1,   1'b0};
    vecs[7] = '{8'd5,   8'd6,   1'b0};
    vecs[8] = '{8'd4,   8'd4,   1'b0};
    vecs[9] = '{8'd100, 8'd111, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready_a), 1);
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_out", int'(out_a), 0);
`ifdef MUL_INV_SAT_FLAG_EN
    chk("rst_out_sat", int'(out_sat_a), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      accept_wait(vecs[i].din, lat);
      chk($sformatf("latency_in%0d", vecs[i].din), lat, 17);
      chk($sformatf("out_in%0d", vecs[i].din), int'(out_a), int'(vecs[i].dout));
      chk($sformatf("unity_in%0d", vecs[i].din), int'(out_b), int'(vecs[i].din));
`ifdef MUL_INV_SAT_FLAG_EN
      chk($sformatf("sat_in%0d", vecs[i].din), int'(out_sat_a), int'(vecs[i].sat));
      chk($sformatf("unity_sat_in%0d", vecs[i].din), int'(out_sat_b), 0);
`endif
      release_out();
    end

    // Reset mid-CALC: leave a non-zero result behind first
    accept_wait(8'd9, lat);
    chk("pre_reset_out", int'(out_a), 10);
    release_out();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd200;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_out_valid", int'(out_valid_a), 0);
    chk("abort_in_ready", int'(in_ready_a), 1);
    chk("abort_out", int'(out_a), 0);
    chk("abort_unity_out", int'(out_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    accept_wait(8'd90, lat);
    chk("post_reset_latency", lat, 17);
    chk("post_reset_out", int'(out_a), 100);
    release_out();

    // Backpressure: hold out_ready low, pulse in_valid with other values
    accept_wait(8'd100, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 1);
      in_data  = 8'(50 + i);
      @(posedge clk);
      #1;
      chk($sformatf("bp_out_c%0d", i), int'(out_a), 111);
      chk($sformatf("bp_valid_c%0d", i), int'(out_valid_a), 1);
      chk($sformatf("bp_in_ready_c%0d", i), int'(in_ready_a), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out();
    chk("bp_idle_in_ready", int'(in_ready_a), 1);
    chk("bp_out_kept", int'(out_a), 111);
    accept_wait(8'd50, lat);
    chk("bp_next_latency", lat, 17);
    chk("bp_next_out", int'(out_a), 56);
    release_out();

    // Back-to-back with in_valid and out_ready held high
    vals = '{10, 20, 30};
    exps = '{11, 22, 33};
    res  = '{0, 0, 0};
    tcy  = '{0, 0, 0};
    nres = 0;
    idx  = 0;
    @(negedge clk);
    in_data   = 8'(vals[0]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      pre = in_ready_a && in_valid;
      @(posedge clk);
      #1;
      if (pre) begin
        idx++;
        if (idx < 3) in_data = 8'(vals[idx]);
        else         in_valid = 1'b0;
      end
      if (out_valid_a && nres < 3) begin
        res[nres] = int'(out_a);
        tcy[nres] = cyc;
        nres++;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_count", nres, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_out%0d", i), res[i], exps[i]);
    end
    chk("b2b_spacing01", tcy[1] - tcy[0], 18);
    chk("b2b_spacing12", tcy[2] - tcy[1], 18);

    // Exhaustive sweep against a rounding reference model
    for (int v = 0; v < 256; v++) begin
      accept_wait(8'(v), lat);
      model = (v * 10 + 4) / 9;
      if (model > 255) model = 255;
      chk($sformatf("sweep_in%0d", v), int'(out_a), model);
      chk($sformatf("sweep_unity_in%0d", v), int'(out_b), v);
`ifdef MUL_INV_SAT_FLAG_EN
      chk($sformatf("sweep_sat_in%0d", v), int'(out_sat_a), (v * 10 + 4) / 9 > 255 ? 1 : 0);
`endif
      release_out();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
